rd53_to_tot_counter: RTL
========================

RD53_TO_TOT_COUNTER -- requirements
Module: rd53_to_tot_counter

Interface
REQ-001 SHALL have parameter TOT_W, default 4: width of the ToT word in clock cycles.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: number of discriminator synchronizer flops; legal values are 2 or 3.
REQ-003 SHALL have port CLK, input, 1 bit: single clock; all logic uses the rising edge.
REQ-004 SHALL have port RESET, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port VOUTP_TO, input, 1 bit: positive discriminator latch output from the TO analog front end.
REQ-006 SHALL have port VOUTN_TO, input, 1 bit: negative discriminator latch output.
REQ-007 SHALL have port PIX_EN, input, 1 bit: pixel enable; 0 aborts counting and masks hits.
REQ-008 SHALL have port TOT, output, TOT_W bits: measured ToT, valid while TOT_VALID=1.
REQ-009 SHALL have port TOT_VALID, output, 1 bit: output buffer holds a hit.
REQ-010 SHALL have port TOT_READY, input, 1 bit: downstream accepts the hit; transfer occurs when TOT_VALID && TOT_READY.
REQ-011 SHALL have port LOST_CNT, output, 8 bits: saturating count of hits dropped because the buffer was full.

Function
REQ-012 SHALL decode the raw hit as VOUTP_TO && !VOUTN_TO; both inputs equal SHALL decode as no hit.
REQ-013 SHALL pass the raw hit through SYNC_STAGES flops to form hit_s; no other logic SHALL sample the raw hit.
REQ-014 SHALL use FSM states IDLE, COUNT and WAIT_LOW.
REQ-015 IDLE: on hit_s=1 and PIX_EN=1, SHALL load cnt=1 and go to COUNT.
REQ-016 IDLE: if hit_s=1 while PIX_EN=0, SHALL go to WAIT_LOW; this prevents counting a partial pulse.
REQ-017 COUNT: while hit_s=1, SHALL increment cnt by 1 each cycle and saturate at 2^TOT_W-1 with no wrap.
REQ-018 COUNT: on hit_s=0, SHALL deliver cnt and return to IDLE; ToT therefore equals the number of cycles hit_s was high (saturated).
REQ-019 Delivery: if the buffer is empty, or drains in the same cycle (TOT_VALID && TOT_READY), SHALL load TOT and assert TOT_VALID on the next edge.
REQ-020 Delivery: otherwise SHALL discard the hit, leave TOT unchanged and increment LOST_CNT, saturating at 255.
REQ-021 Latency: SHALL assert TOT_VALID exactly 1 cycle after the first cycle in which hit_s=0.
REQ-022 SHALL hold TOT_VALID and TOT stable until the handshake completes; with no new load, TOT_VALID SHALL clear the cycle after the transfer.
REQ-023 PIX_EN falling while in COUNT: SHALL discard cnt (not counted as lost) and go to WAIT_LOW.
REQ-024 WAIT_LOW: SHALL return to IDLE when hit_s=0; it SHALL never deliver.
REQ-025 Counting SHALL continue while TOT_VALID=1; the buffer state SHALL NOT block measurement.
REQ-026 A new rising edge of hit_s in the same cycle as the return to IDLE SHALL be seen in the following cycle; a minimum 1-cycle gap is required.

Reset
REQ-027 RESET=1 SHALL asynchronously force: state=IDLE, cnt=0, sync flops=0, TOT=0, TOT_VALID=0, LOST_CNT=0.
REQ-028 Release of RESET during a high hit SHALL go to WAIT_LOW; a hit already in progress is not measured.

Configuration
REQ-029 With RD53_TO_HITOR_EN defined, SHALL add output HIT_OR, 1 bit: equals hit_s && PIX_EN, registered, reset value 0.
REQ-030 Without RD53_TO_HITOR_EN, SHALL omit the HIT_OR port and its logic; all other behaviour is identical.

Structure
REQ-031 SHALL take the FSM state enum (IDLE/COUNT/WAIT_LOW), the default TOT_W and the LOST_CNT width from shared package rd53_to_pkg.
REQ-032 SHALL instantiate the synchronizer as sub-module rd53_to_hit_sync, parameterized by SYNC_STAGES.

Verification
REQ-033 PIX_EN=1, VOUTP=1/VOUTN=0 for 5 cycles, READY=1 -> TOT=5, single VALID pulse, LOST_CNT=0.
REQ-034 Hit held 40 cycles with TOT_W=4 -> TOT=15 (saturated), delivered 1 cycle after hit_s falls.
REQ-035 READY=0, three 3-cycle hits separated by 2-cycle gaps -> TOT=3 held, LOST_CNT=2; READY=1 drains exactly one word.
REQ-036 PIX_EN dropped mid-hit at cycle 3 of 6 -> no VALID, LOST_CNT unchanged; next clean 2-cycle hit -> TOT=2.
REQ-037 VOUTP=VOUTN=1 for 10 cycles -> no hit; RESET asserted mid-COUNT -> all outputs 0 immediately, and a hit high at release yields no delivery.
REQ-038 Compile with RD53_TO_HITOR_EN -> HIT_OR follows hit_s with 1-cycle delay and is forced to 0 while PIX_EN=0.

Source files
------------

// File: rtl/rd53_to_pkg.sv
// Shared types and sizing for the RD53 TO time-over-threshold counter.
// Pure declarations: no latency, no flow control.
// Consumers import rd53_to_pkg::* to pick up the FSM encoding and default widths.
package rd53_to_pkg;

    localparam int TOT_W_DEF = 4;
    localparam int LOST_W    = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COUNT    = 2'd1,
        WAIT_LOW = 2'd2
    } state_t;

endpackage

// File: rtl/rd53_to_hit_sync.sv
// Decodes the TO discriminator pair into a raw hit and synchronizes it into CLK.
// Latency: SYNC_STAGES cycles from raw hit to hit_s; no backpressure (free-running).
// primed rises once every stage holds a post-reset sample, so hit_s is trustworthy.
module rd53_to_hit_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic voutp,
    input  logic voutn,
    output logic hit_s,
    output logic primed
);

    // SYNC_STAGES must be 2 or 3; a single stage would leave no metastability margin.
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] fill_q;
    logic                   hit_raw;

    // Equal inputs (both high or both low) are a non-hit.
    assign hit_raw = voutp & ~voutn;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            fill_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], hit_raw};
            fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign hit_s  = sync_q[SYNC_STAGES-1];
    assign primed = fill_q[SYNC_STAGES-1];

endmodule

// File: rtl/rd53_to_tot_counter.sv
// Measures ToT of the synchronized TO hit and offers it through a one-word valid/ready buffer.
// Latency: TOT_VALID rises 1 cycle after the first low cycle of hit_s (SYNC_STAGES+1 after raw fall).
// Backpressure: a full, undrained buffer drops the new word and bumps LOST_CNT; optional HIT_OR via RD53_TO_HITOR_EN.
module rd53_to_tot_counter
    import rd53_to_pkg::*;
#(
    parameter int TOT_W       = TOT_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              VOUTP_TO,
    input  logic              VOUTN_TO,
    input  logic              PIX_EN,
    output logic [TOT_W-1:0]  TOT,
    output logic              TOT_VALID,
    input  logic              TOT_READY,
    output logic [LOST_W-1:0] LOST_CNT
`ifdef RD53_TO_HITOR_EN
    ,
    output logic              HIT_OR
`endif
);

    localparam logic [TOT_W-1:0]  CNT_MAX  = '1;
    localparam logic [LOST_W-1:0] LOST_MAX = '1;

    logic             hit_s;
    logic             sync_primed;
    logic             fresh;
    state_t           state;
    state_t           state_nxt;
    logic [TOT_W-1:0] cnt;
    logic [TOT_W-1:0] cnt_nxt;
    logic             deliver;
    logic             buf_free;

    rd53_to_hit_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_hit_sync (
        .clk    (CLK),
        .rst    (RESET),
        .voutp  (VOUTP_TO),
        .voutn  (VOUTN_TO),
        .hit_s  (hit_s),
        .primed (sync_primed)
    );

    // fresh covers the first trustworthy hit_s sample after reset: a hit already
    // high at that point started before release and must not be measured.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            fresh <= 1'b1;
        end else if (sync_primed) begin
            fresh <= 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        deliver   = 1'b0;
        case (state)
            IDLE: begin
                if (hit_s) begin
                    if (PIX_EN && !fresh) begin
                        cnt_nxt   = TOT_W'(1);
                        state_nxt = COUNT;
                    end else begin
                        state_nxt = WAIT_LOW;
                    end
                end
            end
            COUNT: begin
                if (!PIX_EN) begin
                    cnt_nxt   = '0;
                    state_nxt = WAIT_LOW;
                end else if (hit_s) begin
                    if (cnt != CNT_MAX) begin
                        cnt_nxt = cnt + TOT_W'(1);
                    end
                end else begin
                    deliver   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WAIT_LOW: begin
                if (!hit_s) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // The buffer accepts a new word when empty or when it drains on this same edge.
    assign buf_free = !TOT_VALID || TOT_READY;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            TOT       <= '0;
            TOT_VALID <= 1'b0;
            LOST_CNT  <= '0;
        end else begin
            if (deliver && buf_free) begin
                TOT       <= cnt;
                TOT_VALID <= 1'b1;
            end else begin
                if (TOT_VALID && TOT_READY) begin
                    TOT_VALID <= 1'b0;
                end
                if (deliver && (LOST_CNT != LOST_MAX)) begin
                    LOST_CNT <= LOST_CNT + LOST_W'(1);
                end
            end
        end
    end

`ifdef RD53_TO_HITOR_EN
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            HIT_OR <= 1'b0;
        end else begin
            HIT_OR <= hit_s & PIX_EN;
        end
    end
`endif

endmodule
